// File: rtl/wmc_cycle_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wmc_cycle_timer_pkg
//  Description : Shared definitions for the WMC phase timer: state encoding
//                and the min/sec field widths also used by the WMC and the
//                front-panel display driver.
//  Revision    : 1.0  initial release
// ============================================================================
package wmc_cycle_timer_pkg;

    // Field widths shared with the controller and the display driver.
    localparam int MIN_W = 7;
    localparam int SEC_W = 6;

    // Seconds reload value when a minute boundary is crossed.
    localparam logic [SEC_W-1:0] C_SEC_LAST = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : wmc_cycle_timer_pkg
`default_nettype wire

// File: rtl/wmc_cycle_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : wmc_cycle_timer_prescaler
//  Description : Mod-TICKS_PER_SEC counter producing the one-second tick.
//                CLR has priority over EN; TICK is combinational on
//                terminal count while enabled. The count holds when EN is low.
//  Ports       : CLOCK  in  system clock
//                RESET  in  synchronous active-high reset
//                CLR    in  synchronous clear (priority over EN)
//                EN     in  count enable
//                TICK   out terminal count & EN
//  Revision    : 1.0  initial release
// ============================================================================
module wmc_cycle_timer_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int                 C_CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [C_CNT_W-1:0] C_TERM  = C_CNT_W'(TICKS_PER_SEC - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               w_term;

    assign w_term = (r_cnt == C_TERM);
    assign TICK   = EN & w_term;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : wmc_cycle_timer_prescaler
`default_nettype wire

// File: rtl/wmc_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wmc_cycle_timer
//  Description : Phase countdown timer for the washing machine controller.
//                A rising edge on T20START loads DURATION_MIN:00 and counts
//                down once per second; T20DONE pulses for one cycle at 0:00.
//                ABORT cancels, PAUSE freezes the count.
//  Ports       : CLOCK     in   system clock
//                RESET     in   synchronous active-high reset
//                T20START  in   start request (rising edge acts)
//                ABORT     in   cancel run, back to idle without T20DONE
//                PAUSE     in   freeze countdown while high
//                T20DONE   out  one-cycle expiry pulse
//                BUSY      out  high while running or paused
//                MIN_LEFT  out  remaining whole minutes
//                SEC_LEFT  out  remaining seconds within the minute
//  Revision    : 1.0  initial release
// ============================================================================
module wmc_cycle_timer
    import wmc_cycle_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int DURATION_MIN  = 20
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             T20START,
    input  logic             ABORT,
    input  logic             PAUSE,
    output logic             T20DONE,
    output logic             BUSY,
    output logic [MIN_W-1:0] MIN_LEFT,
    output logic [SEC_W-1:0] SEC_LEFT
);

    localparam logic [MIN_W-1:0] C_DURATION = MIN_W'(DURATION_MIN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MIN_W-1:0]   r_min;
    logic [MIN_W-1:0]   w_min_nxt;
    logic [SEC_W-1:0]   r_sec;
    logic [SEC_W-1:0]   w_sec_nxt;
    logic               r_t20start_q;
    logic               w_start;
    logic               w_active;
    logic               w_presc_en;
    logic               w_presc_clr;
    logic               w_tick;

    assign w_start  = T20START & ~r_t20start_q;
    assign w_active = (r_state == ST_RUN) || (r_state == ST_PAUSED);

    // The prescaler advances only on cycles that actually count: any edge
    // where PAUSE is sampled high is lost, so each paused cycle adds exactly
    // one cycle to the run (including the resume edge, which counts).
    assign w_presc_en  = w_active & ~PAUSE & ~ABORT & ~w_start;
    assign w_presc_clr = ABORT | w_start;

    wmc_cycle_timer_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .CLR   (w_presc_clr),
        .EN    (w_presc_en),
        .TICK  (w_tick)
    );

    // State register, start-edge register and min/sec counter.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_min        <= '0;
            r_sec        <= '0;
            r_t20start_q <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_t20start_q <= T20START;
        end
    end

    // Next-state / countdown logic. Priority: ABORT > start > PAUSE > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;

        if (ABORT) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
        end else if (w_start) begin
            w_state_nxt = ST_RUN;
            w_min_nxt   = C_DURATION;
            w_sec_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN, ST_PAUSED: begin
                    if (PAUSE) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_state_nxt = ST_RUN;
                        if (w_tick) begin
                            if (r_sec == '0) begin
                                w_sec_nxt = C_SEC_LAST;
                                w_min_nxt = r_min - 1'b1;
                            end else if ((r_min == '0) && (r_sec == SEC_W'(1))) begin
                                w_sec_nxt   = '0;
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_sec_nxt = r_sec - 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign T20DONE  = (r_state == ST_DONE);
    assign BUSY     = w_active;
    assign MIN_LEFT = r_min;
    assign SEC_LEFT = r_sec;

endmodule : wmc_cycle_timer
`default_nettype wire
